// File: rtl/pbvi_iter_ctrl.sv
// pbvi_iter_ctrl -- value-iteration sequencer for the PBVI backup pipeline.
//
// Loads an initial alpha set and fires the pipeline with a one-cycle
// step_en pulse. It then waits for step_done, captures the new alpha set
// and compares it entry by entry against the current set. The new set is
// fed back until one of these happens: the largest change is <= epsilon,
// the iteration limit is reached, or the watchdog expires in WAIT.
//
// Ports
//   clk           clock
//   rst_n         synchronous reset, active HIGH (1 = reset)
//   start         begin a solve (accepted in IDLE/DONE only)
//   abort         cancel a running solve; outputs keep alpha/iteration state
//   max_iter      iteration limit, 0 behaves as 1 (sampled live)
//   epsilon       convergence threshold (sampled live)
//   alpha_init    initial alpha set [point][state]
//   step_done     pipeline loop-done pulse (only honoured in WAIT)
//   alpha_step    pipeline alpha output [point][state]
//   action_step   pipeline per-point action
//   step_en       one-cycle pipeline start pulse
//   alpha_cur     alpha set fed to the pipeline / final result
//   point_action  actions from the last captured iteration
//   iter_count    completed iterations (saturating)
//   busy          solve in progress
//   done          solve finished (level, held until next start)
//   converged     with done: epsilon criterion met
//   timeout_err   with done: watchdog fired
module pbvi_iter_ctrl #(
    parameter int unsigned NUM_POINTS = 16,
    parameter int unsigned NUM_STATES = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ITER_W     = 8,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic                                             abort,
    input  logic [ITER_W-1:0]                                max_iter,
    input  logic [DATA_W-1:0]                                epsilon,
    input  logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] alpha_init,
    input  logic                                             step_done,
    input  logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] alpha_step,
    input  logic [NUM_POINTS-1:0][1:0]                       action_step,
    output logic                                             step_en,
    output logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] alpha_cur,
    output logic [NUM_POINTS-1:0][1:0]                       point_action,
    output logic [ITER_W-1:0]                                iter_count,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             converged,
    output logic                                             timeout_err
);

    localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned PT_W = (NUM_POINTS < 2) ? 1 : $clog2(NUM_POINTS);
    localparam int unsigned ST_W = (NUM_STATES < 2) ? 1 : $clog2(NUM_STATES);

    localparam logic [PT_W-1:0] PT_LAST  = PT_W'(NUM_POINTS - 1);
    localparam logic [ST_W-1:0] ST_LAST  = ST_W'(NUM_STATES - 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] alpha_set_t;
    typedef logic [NUM_POINTS-1:0][1:0]                        action_set_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    alpha_set_t  alpha_cur_q, alpha_cur_d;
    alpha_set_t  alpha_new_q, alpha_new_d;
    action_set_t action_q, action_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic        done_q, done_d;
    logic        conv_q, conv_d;
    logic        tmo_q, tmo_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [PT_W-1:0] pt_q, pt_d;
    logic [ST_W-1:0] st_q, st_d;
    logic        chg_q, chg_d;

    logic [DATA_W-1:0] cur_e;
    logic [DATA_W-1:0] new_e;
    logic [DATA_W-1:0] diff;
    logic              chg_all;
    logic [ITER_W:0]   iter_inc;
    logic [ITER_W:0]   iter_lim;

    assign busy         = (state_q == S_LOAD) || (state_q == S_KICK) ||
                          (state_q == S_WAIT) || (state_q == S_CHECK);
    // Abort in KICK suppresses the pulse so the pipeline is never started.
    assign step_en      = (state_q == S_KICK) && !abort;
    assign alpha_cur    = alpha_cur_q;
    assign point_action = action_q;
    assign iter_count   = iter_q;
    assign done         = done_q;
    assign converged    = conv_q;
    assign timeout_err  = tmo_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            alpha_cur_q <= '0;
            alpha_new_q <= '0;
            action_q    <= '0;
            iter_q      <= '0;
            done_q      <= 1'b0;
            conv_q      <= 1'b0;
            tmo_q       <= 1'b0;
            wdog_q      <= '0;
            pt_q        <= '0;
            st_q        <= '0;
            chg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            alpha_cur_q <= alpha_cur_d;
            alpha_new_q <= alpha_new_d;
            action_q    <= action_d;
            iter_q      <= iter_d;
            done_q      <= done_d;
            conv_q      <= conv_d;
            tmo_q       <= tmo_d;
            wdog_q      <= wdog_d;
            pt_q        <= pt_d;
            st_q        <= st_d;
            chg_q       <= chg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        alpha_cur_d = alpha_cur_q;
        alpha_new_d = alpha_new_q;
        action_d    = action_q;
        iter_d      = iter_q;
        done_d      = done_q;
        conv_d      = conv_q;
        tmo_d       = tmo_q;
        wdog_d      = wdog_q;
        pt_d        = pt_q;
        st_d        = st_q;
        chg_d       = chg_q;

        // Absolute difference as larger-minus-smaller: never wraps.
        cur_e    = alpha_cur_q[pt_q][st_q];
        new_e    = alpha_new_q[pt_q][st_q];
        diff     = (new_e >= cur_e) ? (new_e - cur_e) : (cur_e - new_e);
        chg_all  = chg_q | (diff > epsilon);
        // One extra bit so the limit test uses the unsaturated count.
        iter_inc = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
        iter_lim = (max_iter == '0) ? {{ITER_W{1'b0}}, 1'b1} : {1'b0, max_iter};

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                alpha_cur_d = alpha_init;
                iter_d      = '0;
                done_d      = 1'b0;
                conv_d      = 1'b0;
                tmo_d       = 1'b0;
                state_d     = S_KICK;
            end
            S_KICK: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (step_done) begin
                    alpha_new_d = alpha_step;
                    action_d    = action_step;
                    pt_d        = '0;
                    st_d        = '0;
                    chg_d       = 1'b0;
                    state_d     = S_CHECK;
                end else if (wdog_q == WD_LIMIT) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                chg_d = chg_all;
                if (st_q == ST_LAST) begin
                    st_d = '0;
                    pt_d = pt_q + 1'b1;
                end else begin
                    st_d = st_q + 1'b1;
                end
                if ((pt_q == PT_LAST) && (st_q == ST_LAST)) begin
                    alpha_cur_d = alpha_new_q;
                    iter_d      = (&iter_q) ? iter_q : iter_inc[ITER_W-1:0];
                    if (!chg_all) begin
                        conv_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (iter_inc >= iter_lim) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_KICK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything else in a busy state, including a
        // same-cycle step_done or the final CHECK commit.
        if (abort && busy) begin
            state_d     = S_IDLE;
            alpha_cur_d = alpha_cur_q;
            iter_d      = iter_q;
            done_d      = 1'b0;
            conv_d      = 1'b0;
            tmo_d       = 1'b0;
        end
    end

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// Testbench for pbvi_iter_ctrl: acts as host and as a stub backup pipeline.
// Each solve replays a prepared list of pipeline responses; the expected
// outcome is derived from those responses with plain arithmetic.
module tb_pbvi_iter_ctrl;

    localparam int unsigned NP    = 16;
    localparam int unsigned NS    = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 8;
    localparam int unsigned TMO   = 1023;
    localparam int          MAXIT = 8;

    typedef logic [NP-1:0][NS-1:0][DW-1:0] aset_t;
    typedef logic [NP-1:0][1:0]            act_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_h, start, abort;
    logic [IW-1:0] max_iter;
    logic [DW-1:0] epsilon;
    aset_t         alpha_init;
    aset_t         alpha_step = '0;
    act_t          action_step = '0;
    logic          stub_done = 1'b0;
    logic          man_done;
    logic          step_done;
    logic          step_en, busy, done, converged, timeout_err;
    aset_t         alpha_cur;
    act_t          point_action;
    logic [IW-1:0] iter_count;

    assign step_done = stub_done | man_done;

    pbvi_iter_ctrl #(
        .NUM_POINTS(NP),
        .NUM_STATES(NS),
        .DATA_W    (DW),
        .ITER_W    (IW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_h),
        .start       (start),
        .abort       (abort),
        .max_iter    (max_iter),
        .epsilon     (epsilon),
        .alpha_init  (alpha_init),
        .step_done   (step_done),
        .alpha_step  (alpha_step),
        .action_step (action_step),
        .step_en     (step_en),
        .alpha_cur   (alpha_cur),
        .point_action(point_action),
        .iter_count  (iter_count),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .timeout_err (timeout_err)
    );

    // Response script for the stub pipeline.
    aset_t       resp [MAXIT];
    act_t        acts [MAXIT];
    int unsigned lat  [MAXIT];   // WAIT cycles until step_done is seen
    bit          stub_silent = 1'b0;
    int          kicks = 0;
    int          kick_base = 0;
    int          stub_k;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected solve outcome.
    aset_t exp_alpha;
    act_t  exp_act;
    int    exp_iter;
    bit    exp_conv;
    int    exp_busy;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub pipeline: on each step_en, answer with the next scripted response.
    always begin
        @(negedge clk);
        if (step_en === 1'b1) begin
            stub_k = (kicks - kick_base) % MAXIT;
            kicks++;
            if (!stub_silent) begin
                @(posedge clk);
                repeat (lat[stub_k] - 1) @(posedge clk);
                #1;
                alpha_step  = resp[stub_k];
                action_step = acts[stub_k];
                stub_done   = 1'b1;
                @(posedge clk);
                #1;
                stub_done = 1'b0;
            end
        end
    end

    // Iterate the scripted responses: each iteration replaces the alpha set;
    // stop when max |change| <= eps, or after max(max_iter,1) iterations.
    task automatic model_solve();
        int lim, maxd, a;
        exp_alpha = alpha_init;
        exp_act   = point_action;
        exp_iter  = 0;
        exp_conv  = 1'b0;
        exp_busy  = 1;
        lim = (max_iter == 0) ? 1 : int'(max_iter);
        for (int i = 0; i < MAXIT; i++) begin
            maxd = 0;
            for (int p = 0; p < NP; p++)
                for (int s = 0; s < NS; s++) begin
                    a = int'(resp[i][p][s]) - int'(exp_alpha[p][s]);
                    if (a < 0) a = -a;
                    if (a > maxd) maxd = a;
                end
            exp_busy += 1 + int'(lat[i]) + NP * NS;
            exp_alpha = resp[i];
            exp_act   = acts[i];
            exp_iter++;
            if (maxd <= int'(epsilon)) begin
                exp_conv = 1'b1;
                break;
            end
            if (exp_iter >= lim) break;
        end
    endtask

    // Called and returns at a negedge.
    task automatic run_solve(input string nm, input bit hold);
        int cyc, bcyc;
        kick_base = kicks;
        model_solve();
        start = 1'b1;
        cyc   = 0;
        bcyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bcyc++;
            if (!hold) start = 1'b0;
        end while (!(done && !busy) && cyc < 20000);
        start = 1'b0;
        check({nm, "_finished"}, cyc < 20000, 1'b1);
        check({nm, "_done"}, done, 1'b1);
        check({nm, "_conv"}, converged, exp_conv);
        check({nm, "_tmo"}, timeout_err, 1'b0);
        check({nm, "_iter"}, iter_count, exp_iter);
        check({nm, "_alpha"}, alpha_cur, exp_alpha);
        check({nm, "_act"}, point_action, exp_act);
        check({nm, "_kicks"}, kicks - kick_base, exp_iter);
        check({nm, "_busycyc"}, bcyc, exp_busy);
    endtask

    task automatic set_lat(input int unsigned v);
        for (int i = 0; i < MAXIT; i++) lat[i] = v;
    endtask

    task automatic rand_acts();
        for (int i = 0; i < MAXIT; i++) acts[i] = act_t'($urandom);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, busy, 1'b0);
        check({nm, "_done"}, done, 1'b0);
        check({nm, "_conv"}, converged, 1'b0);
        check({nm, "_tmo"}, timeout_err, 1'b0);
        check({nm, "_step_en"}, step_en, 1'b0);
        check({nm, "_iter"}, iter_count, 0);
        check({nm, "_alpha"}, alpha_cur, 0);
        check({nm, "_act"}, point_action, 0);
    endtask

    initial begin
        aset_t fill, prev;
        int cyc, en_at, dn_at, eps_i, mag, dv;
        bit calm;

        rst_h = 1'b1; start = 1'b0; abort = 1'b0; man_done = 1'b0;
        max_iter = '0; epsilon = '0; alpha_init = '0;
        set_lat(3);
        rand_acts();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_h = 1'b0;
        @(negedge clk);

        // T1: stub returns the input unchanged -> converged after 1 iteration.
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++) alpha_init[p][s] = 16'h4000;
        for (int i = 0; i < MAXIT; i++) resp[i] = alpha_init;
        epsilon = 16'd0; max_iter = 8'd5;
        run_solve("t1", 1'b0);

        // T2: +2 per pass, eps=1, limit 3 -> stops at 0x4006, not converged.
        for (int i = 0; i < MAXIT; i++)
            for (int p = 0; p < NP; p++)
                for (int s = 0; s < NS; s++) resp[i][p][s] = 16'h4000 + DW'(2 * (i + 1));
        epsilon = 16'd1; max_iter = 8'd3; set_lat(2); rand_acts();
        run_solve("t2", 1'b0);
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++) fill[p][s] = 16'h4006;
        check("t2_alpha_const", alpha_cur, fill);

        // T3: single-entry delta exactly eps (unchanged), then eps+1 (changed).
        for (int i = 0; i < MAXIT; i++) resp[i] = alpha_init;
        resp[0][15][1] = 16'h4010;
        epsilon = 16'h0010; max_iter = 8'd4; rand_acts();
        run_solve("t3a", 1'b0);
        check("t3a_conv_const", converged, 1'b1);
        resp[0][15][1] = 16'h4011;
        max_iter = 8'd1;
        run_solve("t3b", 1'b0);
        check("t3b_conv_const", converged, 1'b0);

        // T4: silent pipeline -> watchdog. done rises TMO+1 clock edges
        // after the edge that consumed step_en.
        stub_silent = 1'b1; kick_base = kicks; max_iter = 8'd3;
        start = 1'b1; cyc = 0; en_at = -1; dn_at = -1;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (step_en && en_at < 0) en_at = cyc;
            if (done && !busy && dn_at < 0) dn_at = cyc;
        end while (!(done && !busy) && cyc < 3000);
        check("t4_finished", cyc < 3000, 1'b1);
        check("t4_edges", dn_at - en_at - 1, TMO + 1);
        check("t4_tmo", timeout_err, 1'b1);
        check("t4_done", done, 1'b1);
        check("t4_conv", converged, 1'b0);
        check("t4_iter", iter_count, 0);
        check("t4_alpha", alpha_cur, alpha_init);
        check("t4_kicks", kicks - kick_base, 1);
        stub_silent = 1'b0;

        // T5: abort in CHECK, then a stray step_done while idle.
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++) alpha_init[p][s] = DW'($urandom_range(16'h1000, 16'hE000));
        for (int i = 0; i < MAXIT; i++) begin
            resp[i] = alpha_init;
            resp[i][3][0] = alpha_init[3][0] + 16'h0100;
        end
        epsilon = 16'd0; max_iter = 8'd4; set_lat(2);
        kick_base = kicks;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (kicks == kick_base && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_step_en", step_en, 1'b0);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle_busy", busy, 1'b0);
        check("t5_idle_done", done, 1'b0);
        check("t5_kicks", kicks - kick_base, 1);
        check("t5_alpha_kept", alpha_cur, alpha_init);
        check("t5_iter_kept", iter_count, 0);
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++) alpha_init[p][s] = DW'($urandom_range(16'h1000, 16'hE000));
        for (int i = 0; i < MAXIT; i++) resp[i] = alpha_init;
        rand_acts();
        run_solve("t5_restart", 1'b0);

        // T6: max_iter=0 behaves as 1; start held high during the solve.
        for (int i = 0; i < MAXIT; i++)
            for (int p = 0; p < NP; p++)
                for (int s = 0; s < NS; s++) resp[i][p][s] = alpha_init[p][s] + DW'(16'h0100 * (i + 1));
        max_iter = 8'd0; epsilon = 16'd0; rand_acts();
        run_solve("t6", 1'b1);

        // T6b: reset during WAIT clears every output on the next cycle.
        set_lat(30);
        kick_base = kicks;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (kicks == kick_base && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        rst_h = 1'b1;
        @(negedge clk);
        rst_h = 1'b0;
        check_all_zero("t6_rst");
        repeat (40) @(negedge clk);

        // Randomised solves.
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0: eps_i = 0;
                1: eps_i = 16'h10;
                2: eps_i = 16'h20;
                default: eps_i = 16'h40;
            endcase
            epsilon  = DW'(eps_i);
            max_iter = IW'($urandom_range(0, 5));
            for (int p = 0; p < NP; p++)
                for (int s = 0; s < NS; s++) alpha_init[p][s] = DW'($urandom_range(16'h1000, 16'hE000));
            prev = alpha_init;
            for (int i = 0; i < MAXIT; i++) begin
                calm = ($urandom_range(0, 2) == 0);
                for (int p = 0; p < NP; p++)
                    for (int s = 0; s < NS; s++) begin
                        mag = calm ? $urandom_range(0, eps_i) : $urandom_range(0, 16'h60);
                        dv  = $urandom_range(0, 1) ? mag : -mag;
                        resp[i][p][s] = DW'(int'(prev[p][s]) + dv);
                    end
                prev   = resp[i];
                acts[i] = act_t'($urandom);
                lat[i]  = $urandom_range(1, 4);
            end
            run_solve($sformatf("rnd%0d", t), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
